// File: rtl/iir_sequencer.sv
// -----------------------------------------------------------------------------
// iir_sequencer
//
// Control and arithmetic core of a second-order direct-form-II IIR filter.
// On each accepted sample strobe it runs a five-step multiply-accumulate
// schedule (M1..M5). Each step drives the select lines of an external
// coefficient/operand multiplexer and consumes the three operands it returns.
//
//   f[k] = u[k] + a1*f[k-1] + a2*f[k-2]
//   y[k] = b0*f[k] + b1*f[k-1] + b2*f[k-2]
//
// Parameters
//   W  data word width (legacy name "ancho"), signed two's-complement
//   F  fractional bits, shared by coefficients and data
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high; clears every register
//   start      sample strobe, only looked at in IDLE
//   u_in       new input sample, captured together with start
//   operando1  coefficient from the mux
//   operando2  state operand from the mux (fk/fk1/fk2)
//   operando3  addend from the mux (Uk/acum/0)
//   bar1       coefficient select: 0=a1 1=a2 2=b0 3=b1 4=b2 5=zero
//   bar2       state select:       0=fk 1=fk1 2=fk2 3=zero
//   bar3       addend select:      0=Uk 1=acum 2=zero
//   fk,fk1,fk2 filter state registers
//   acum       accumulator register
//   Uk         latched input sample
//   yk         filter output, held until the next sample completes
//   busy       high while a schedule is running
//   done       one-cycle pulse in the cycle after yk is updated
// -----------------------------------------------------------------------------
module iir_sequencer #(
    parameter int W = 32,
    parameter int F = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] u_in,
    input  logic [W-1:0] operando1,
    input  logic [W-1:0] operando2,
    input  logic [W-1:0] operando3,
    output logic [2:0]   bar1,
    output logic [1:0]   bar2,
    output logic [1:0]   bar3,
    output logic [W-1:0] fk,
    output logic [W-1:0] fk1,
    output logic [W-1:0] fk2,
    output logic [W-1:0] acum,
    output logic [W-1:0] Uk,
    output logic [W-1:0] yk,
    output logic         busy,
    output logic         done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_M1   = 3'd1;
    localparam logic [2:0] S_M2   = 3'd2;
    localparam logic [2:0] S_M3   = 3'd3;
    localparam logic [2:0] S_M4   = 3'd4;
    localparam logic [2:0] S_M5   = 3'd5;

    logic [2:0]   state_q, state_d;
    logic [W-1:0] fk_q,   fk_d;
    logic [W-1:0] fk1_q,  fk1_d;
    logic [W-1:0] fk2_q,  fk2_d;
    logic [W-1:0] acum_q, acum_d;
    logic [W-1:0] uk_q,   uk_d;
    logic [W-1:0] yk_q,   yk_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic signed [2*W-1:0] prod_s;
    logic signed [2*W-1:0] quot_s;
    logic signed [2*W:0]   sum_s;
    logic        [W-1:0]   mac_s;

    // Clamp a (2W+1)-bit signed sum into the signed W-bit range. The value
    // fits only when every bit from the sign down to bit W-1 agrees.
    function automatic logic [W-1:0] sat_fn(input logic signed [2*W:0] v);
        logic [W+1:0] top;
        top = v[2*W:W-1];
        if ((top == {(W+2){1'b0}}) || (top == {(W+2){1'b1}})) begin
            return v[W-1:0];
        end else if (v[2*W]) begin
            return {1'b1, {(W-1){1'b0}}};
        end else begin
            return {1'b0, {(W-1){1'b1}}};
        end
    endfunction

    // Shared MAC datapath: signed product, floor shift by F, add, saturate.
    always_comb begin
        prod_s = $signed({{W{operando1[W-1]}}, operando1})
               * $signed({{W{operando2[W-1]}}, operando2});
        quot_s = prod_s >>> F;
        sum_s  = $signed({quot_s[2*W-1], quot_s})
               + $signed({{(W+1){operando3[W-1]}}, operando3});
        mac_s  = sat_fn(sum_s);
    end

    // Moore decode of the mux selects from the state register.
    always_comb begin
        case (state_q)
            S_M1:    begin bar1 = 3'd0; bar2 = 2'd1; bar3 = 2'd0; end
            S_M2:    begin bar1 = 3'd1; bar2 = 2'd2; bar3 = 2'd1; end
            S_M3:    begin bar1 = 3'd2; bar2 = 2'd0; bar3 = 2'd2; end
            S_M4:    begin bar1 = 3'd3; bar2 = 2'd1; bar3 = 2'd1; end
            S_M5:    begin bar1 = 3'd4; bar2 = 2'd2; bar3 = 2'd1; end
            default: begin bar1 = 3'd5; bar2 = 2'd3; bar3 = 2'd2; end
        endcase
    end

    // Next-state and register-update selection for each schedule step.
    always_comb begin
        state_d = state_q;
        fk_d    = fk_q;
        fk1_d   = fk1_q;
        fk2_d   = fk2_q;
        acum_d  = acum_q;
        uk_d    = uk_q;
        yk_d    = yk_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    uk_d    = u_in;
                    state_d = S_M1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_M1: begin
                acum_d  = mac_s;
                state_d = S_M2;
            end
            S_M2: begin
                acum_d  = mac_s;
                fk_d    = mac_s;
                state_d = S_M3;
            end
            S_M3: begin
                // addend select is zero here, so the MAC yields b0*fk alone
                acum_d  = mac_s;
                state_d = S_M4;
            end
            S_M4: begin
                acum_d  = mac_s;
                state_d = S_M5;
            end
            S_M5: begin
                // the delay-line shift is committed only on this edge, so an
                // aborted schedule never leaves a partial shift behind
                acum_d  = mac_s;
                yk_d    = mac_s;
                fk2_d   = fk1_q;
                fk1_d   = fk_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            fk_q    <= {W{1'b0}};
            fk1_q   <= {W{1'b0}};
            fk2_q   <= {W{1'b0}};
            acum_q  <= {W{1'b0}};
            uk_q    <= {W{1'b0}};
            yk_q    <= {W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fk_q    <= fk_d;
            fk1_q   <= fk1_d;
            fk2_q   <= fk2_d;
            acum_q  <= acum_d;
            uk_q    <= uk_d;
            yk_q    <= yk_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fk   = fk_q;
    assign fk1  = fk1_q;
    assign fk2  = fk2_q;
    assign acum = acum_q;
    assign Uk   = uk_q;
    assign yk   = yk_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_iir_sequencer.sv
// -----------------------------------------------------------------------------
// tb_iir_sequencer
//
// Self-checking bench for iir_sequencer. The bench plays the role of the
// external coefficient/operand multiplexer and keeps its own reference model
// of the filter arithmetic and delay line. Expected results of each sample
// are queued when the sample is started and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_iir_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] u_in;
    logic [31:0] operando1, operando2, operando3;
    logic [2:0]  bar1;
    logic [1:0]  bar2, bar3;
    logic [31:0] fk, fk1, fk2, acum, Uk, yk;
    logic        busy, done;

    iir_sequencer #(.W(32), .F(16)) dut (
        .clk(clk), .reset(reset), .start(start), .u_in(u_in),
        .operando1(operando1), .operando2(operando2), .operando3(operando3),
        .bar1(bar1), .bar2(bar2), .bar3(bar3),
        .fk(fk), .fk1(fk1), .fk2(fk2), .acum(acum), .Uk(Uk), .yk(yk),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Q16.16 coefficients
    localparam logic [31:0] A1 = 32'd32112;
    localparam logic [31:0] A2 = 32'hFFFF_C54C;   // -15028
    localparam logic [31:0] B0 = 32'd3;
    localparam logic [31:0] B1 = 32'd6;
    localparam logic [31:0] B2 = 32'd3;

    // mux model, with an override for driving operands directly
    logic        ovr;
    logic [31:0] ov1, ov2, ov3;
    always_comb begin
        operando1 = 32'd0;
        operando2 = 32'd0;
        operando3 = 32'd0;
        if (ovr) begin
            operando1 = ov1;
            operando2 = ov2;
            operando3 = ov3;
        end else begin
            case (bar1)
                3'd0: operando1 = A1;
                3'd1: operando1 = A2;
                3'd2: operando1 = B0;
                3'd3: operando1 = B1;
                3'd4: operando1 = B2;
                default: operando1 = 32'd0;
            endcase
            case (bar2)
                2'd0: operando2 = fk;
                2'd1: operando2 = fk1;
                2'd2: operando2 = fk2;
                default: operando2 = 32'd0;
            endcase
            case (bar3)
                2'd0: operando3 = Uk;
                2'd1: operando3 = acum;
                default: operando3 = 32'd0;
            endcase
        end
    end

    typedef struct {
        logic [31:0] yk;
        logic [31:0] fk;
        logic [31:0] fk1;
        logic [31:0] fk2;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] u;
        bit          has_ref;
        logic [31:0] r_m1;
        logic [31:0] r_yk;
        logic [31:0] r_fk;
        logic [31:0] r_fk1;
        logic [31:0] r_fk2;
    } vec_t;

    // reference delay line
    logic [31:0] mf1 = 32'd0;
    logic [31:0] mf2 = 32'd0;
    int unsigned last_done = 0;
    bit          last_done_ok = 1'b0;

    // saturating Q16.16 multiply-accumulate, computed in 64-bit integers
    function automatic logic [31:0] mac(input logic [31:0] c, input logic [31:0] x,
                                        input logic [31:0] add);
        longint p;
        longint s;
        p = longint'($signed(c)) * longint'($signed(x));
        s = (p >>> 16) + longint'($signed(add));
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_fk"},   fk,   32'd0);
        chk({tag, "_fk1"},  fk1,  32'd0);
        chk({tag, "_fk2"},  fk2,  32'd0);
        chk({tag, "_acum"}, acum, 32'd0);
        chk({tag, "_Uk"},   Uk,   32'd0);
        chk({tag, "_yk"},   yk,   32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_sel"},  {25'd0, bar1, bar2, bar3}, {25'd0, 3'd5, 2'd3, 2'd2});
    endtask

    // Runs one sample starting at a negedge; returns at the negedge of the
    // done cycle so the next sample can be strobed back to back.
    task automatic run_sample(input vec_t v, input bit hold, input bit glitch, input string tag);
        logic [31:0] st[5];
        logic [6:0]  sel_exp[5];
        exp_t        e;
        int unsigned c0;
        sel_exp[0] = {3'd0, 2'd1, 2'd0};
        sel_exp[1] = {3'd1, 2'd2, 2'd1};
        sel_exp[2] = {3'd2, 2'd0, 2'd2};
        sel_exp[3] = {3'd3, 2'd1, 2'd1};
        sel_exp[4] = {3'd4, 2'd2, 2'd1};
        st[0] = mac(A1, mf1, v.u);
        st[1] = mac(A2, mf2, st[0]);
        st[2] = mac(B0, st[1], 32'd0);
        st[3] = mac(B1, mf1, st[2]);
        st[4] = mac(B2, mf2, st[3]);
        e.yk = st[4]; e.fk = st[1]; e.fk1 = st[1]; e.fk2 = mf1;
        mf2 = mf1;
        mf1 = st[1];
        if (v.has_ref) begin
            st[0] = v.r_m1; st[1] = v.r_fk; st[4] = v.r_yk;
            e.yk = v.r_yk; e.fk = v.r_fk; e.fk1 = v.r_fk1; e.fk2 = v.r_fk2;
        end
        sb.push_back(e);
        start = 1'b1;
        u_in  = v.u;
        @(posedge clk); #1;
        c0 = cyc;
        if (!hold) start = 1'b0;
        u_in = $urandom;
        chk({tag, "_uk_latch"}, Uk, v.u);
        chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("%s_sel_m%0d", tag, k + 1), {25'd0, bar1, bar2, bar3}, {25'd0, sel_exp[k]});
            chk($sformatf("%s_busy_m%0d", tag, k + 1), {31'd0, busy}, 32'd1);
            if (glitch && k == 1) begin
                start = 1'b1;
                u_in  = v.u ^ 32'h5A5A_0000;
            end
            @(posedge clk); #1;
            if (glitch && k == 1 && !hold) start = 1'b0;
            chk($sformatf("%s_acum_m%0d", tag, k + 1), acum, st[k]);
            if (k == 1) chk({tag, "_fk_m2"}, fk, st[1]);
        end
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_uk_hold"}, Uk, v.u);
        @(negedge clk);
        for (int t = 0; t < 8 && done !== 1'b1; t++) @(negedge clk);
        if (done !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_done_timeout: got done=%b, expected 1", tag, done);
        end else if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_sb_empty: got done=1, expected no pulse", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_yk"},  yk,  e.yk);
            chk({tag, "_fk"},  fk,  e.fk);
            chk({tag, "_fk1"}, fk1, e.fk1);
            chk({tag, "_fk2"}, fk2, e.fk2);
            chk({tag, "_latency"}, cyc - c0, 32'd5);
            if (hold && last_done_ok) chk({tag, "_period"}, cyc - last_done, 32'd6);
        end
        last_done = cyc;
        last_done_ok = 1'b1;
    endtask

    task automatic sat_case(input string nm, input logic [31:0] o1, input logic [31:0] o2,
                            input logic [31:0] o3, input logic [31:0] exp);
        @(negedge clk);
        start = 1'b1;
        u_in  = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        ovr = 1'b1; ov1 = o1; ov2 = o2; ov3 = o3;
        @(posedge clk); #1;
        chk(nm, acum, exp);
        ovr   = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mf1 = 32'd0;
        mf2 = 32'd0;
    endtask

    vec_t vt[7];
    vec_t vh;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{32'h0001_0000, 1'b1, 32'd65536, 32'd3, 32'd65536, 32'd65536, 32'd0};
        vt[1] = '{32'h0000_0000, 1'b1, 32'd32112, 32'd7, 32'd32112, 32'd32112, 32'd65536};
        vt[2] = '{32'h0001_8000, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        vt[3] = '{32'hFFFE_0000, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        vt[4] = '{32'h7FFF_FFFF, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        vt[5] = '{32'h8000_0000, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        vt[6] = '{32'h0000_1234, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

        reset = 1'b1; start = 1'b0; u_in = 32'd0;
        ovr = 1'b0; ov1 = 32'd0; ov2 = 32'd0; ov3 = 32'd0;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // table-driven samples, back to back
        for (int i = 0; i < 7; i++) run_sample(vt[i], 1'b0, 1'b0, $sformatf("vec%0d", i));

        // start pulsed during M2 must be ignored
        vh = '{32'h0000_4000, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        @(negedge clk);
        run_sample(vh, 1'b0, 1'b1, "glitch");
        @(posedge clk); #1;
        chk("glitch_no_extra_busy", {31'd0, busy}, 32'd0);
        chk("glitch_no_extra_uk", Uk, 32'h0000_4000);

        // reset during M3 clears everything asynchronously
        @(negedge clk);
        start = 1'b1; u_in = 32'h0001_0000;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("rst_m3_sel", {25'd0, bar1, bar2, bar3}, {25'd0, 3'd2, 2'd0, 2'd2});
        #2;
        reset = 1'b1;
        #1;
        chk_zero("rst_mid");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mf1 = 32'd0; mf2 = 32'd0;
        repeat (4) @(negedge clk);
        chk("rst_no_done", {31'd0, done}, 32'd0);
        run_sample(vt[0], 1'b0, 1'b0, "post_rst");
        chk("post_rst_yk3", yk, 32'd3);

        // saturation and floor truncation with operands driven directly
        sat_case("sat_pos", 32'h0001_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        sat_case("sat_neg", 32'h0001_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        sat_case("floor_trunc", 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF);

        // start held high: one sample every 6 cycles
        vh = '{32'h0001_0000, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        @(negedge clk);
        last_done_ok = 1'b0;
        for (int i = 0; i < 3; i++) run_sample(vh, 1'b1, 1'b0, $sformatf("held%0d", i));
        start = 1'b0;
        @(posedge clk); #1;
        chk("held_stop_busy", {31'd0, busy}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
